// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the synchronous instruction memory,
// buffers returned words with their PCs and presents them to decode via valid/ready.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_address;
  logic              r_pending;
  logic [ADDR_W-1:0] r_pending_pc;
  logic [ADDR_W-1:0] r_buf_pc    [DEPTH];
  logic [ADDR_W-1:0] r_buf_instr [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CNT_W:0]    w_in_flight;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop       = (r_count != '0) && if_ready;
  assign w_push      = r_pending && !redirect_valid;
  // Buffered + in-flight entries after this cycle's pop; an issue only when a slot stays free.
  assign w_in_flight = {1'b0, r_count} + (CNT_W+1)'(r_pending) - (CNT_W+1)'(w_pop);
  assign w_issue     = !redirect_valid && (w_in_flight < (CNT_W+1)'(DEPTH));
  assign w_pc_next   = r_pc + ADDR_W'(4);
  assign w_target    = redirect_pc & ~ADDR_W'(3);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_address    <= RESET_PC;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else if (redirect_valid) begin
      r_pc      <= w_target;
      r_address <= w_target;
      r_pending <= 1'b0;
    end else if (w_issue) begin
      r_pc         <= w_pc_next;
      r_address    <= w_pc_next;
      r_pending    <= 1'b1;
      r_pending_pc <= r_pc;
    end else begin
      r_pending <= 1'b0;
    end
  end

  // NOTE: the buffer array is reset along with the pointers so the head outputs
  // read as zero out of reset instead of undefined storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // A pop this cycle has already been taken by decode; everything else is wrong-path.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf_pc[r_wr_ptr]    <= r_pending_pc;
        r_buf_instr[r_wr_ptr] <= instruction;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign address  = r_address;
  assign if_valid = (r_count != '0);
  assign if_instr = r_buf_instr[r_rd_ptr];
  assign if_pc    = r_buf_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model returns ~address one cycle later,
// a scoreboard queue holds the expected in-order instruction stream.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic [31:0] address, instruction, if_instr, if_pc;
  logic        if_valid;
  logic [31:0] hi_address, hi_instruction, hi_instr, hi_pc;
  logic        hi_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      mon_e;
  logic [31:0] model_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
    .clk(clk), .rst_n(rst_n), .address(hi_address), .instruction(hi_instruction),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(hi_valid), .if_ready(if_ready), .if_instr(hi_instr), .if_pc(hi_pc)
  );

  always @(posedge clk) begin
    instruction    <= ~address;
    hi_instruction <= ~hi_address;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must be the next one of the current path.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: model_pc, instr: ~model_pc});
        model_pc += 32'd4;
      end
      if (if_valid && if_ready) begin
        mon_e = exp_q.pop_front();
        check("pop_pc", if_pc, mon_e.pc);
        check("pop_instr", if_instr, mon_e.instr);
      end
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      check("no_overflow", 32'(dut.r_count <= 2'd2), 32'd1);
    end
  end

  // Called at posedge+1 with rst_n low; checks the startup stream of both instances.
  task automatic release_and_check(input string tag);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check({tag, "_addr"}, address, 32'(4 * c));
      check({tag, "_valid"}, 32'(if_valid), 32'(c >= 2));
      check({tag, "_hi_valid"}, 32'(hi_valid), 32'(c >= 2));
      if (c >= 2) begin
        check({tag, "_pc"}, if_pc, 32'(4 * (c - 2)));
        check({tag, "_instr"}, if_instr, ~32'(4 * (c - 2)));
        check({tag, "_hi_pc"}, hi_pc, 32'hFFFF_FFF8 + 32'(4 * (c - 2)));
        check({tag, "_hi_instr"}, hi_instr, ~(32'hFFFF_FFF8 + 32'(4 * (c - 2))));
      end
    end
  endtask

  task automatic expect_target(input string tag, input logic [31:0] target);
    step(); redirect_valid = 1'b0; if_ready = 1'b1;
    @(negedge clk); check({tag, "_r1_valid"}, 32'(if_valid), 32'd0);
    step();
    @(negedge clk); check({tag, "_r2_valid"}, 32'(if_valid), 32'd0);
    step();
    @(negedge clk);
    check({tag, "_r3_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_r3_pc"}, if_pc, target);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a0, p0;
    rst_n = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", address, 32'h0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_hi_addr", hi_address, 32'hFFFF_FFF8);
    release_and_check("start");

    // Stall for five cycles: address and head frozen.
    step(); if_ready = 1'b0;
    @(negedge clk);
    a0 = address; p0 = if_pc;
    check("stall_valid0", 32'(if_valid), 32'd1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("stall_addr", address, a0);
      check("stall_head", if_pc, p0);
      check("stall_valid", 32'(if_valid), 32'd1);
    end
    step(); if_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Redirect with two entries buffered and no pop.
    step(); if_ready = 1'b0;
    repeat (2) @(negedge clk);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk); check("redir_buffered", 32'(if_valid), 32'd1);
    expect_target("redir", 32'h0000_0100);

    // Redirect in the same cycle as an accepted pop.
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk); check("redir_pop_valid", 32'(if_valid), 32'd1);
    expect_target("redir_pop", 32'h0000_0200);

    // Back-to-back redirects: the second target wins.
    step(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    step(); redirect_pc = 32'h0000_0402;
    @(negedge clk);
    expect_target("redir_b2b", 32'h0000_0400);

    // Reset asserted mid-stall with two entries buffered.
    step(); if_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(if_valid), 32'd0);
    check("midrst_pc", if_pc, 32'h0);
    check("midrst_instr", if_instr, 32'h0);
    check("midrst_addr", address, 32'h0);
    step(); if_ready = 1'b1;
    release_and_check("restart");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
